// File: rtl/asi_beat_addr_gen.sv
// Per-beat address generator: accepts one AXI burst request per handshake and
// expands it into a stream of beat descriptors (address, ID, index, last, error)
// for the write-data and read-data engines.
//
// Handshakes: a transfer on either channel happens in a cycle where its valid
// and ready are both high at the rising edge of ACLK. A producer holding valid
// keeps its payload stable until the transfer; BEAT_VALID never drops without a
// transfer except on reset, and AXREADY never looks at AXVALID.
module asi_beat_addr_gen #(
  parameter int AXI_AW     = 40,
  parameter int AXI_IW     = 8,
  parameter int AXI_LW     = 8,
  parameter int AXI_SW     = 3,
  parameter int AXI_BURSTW = 2,
  parameter int SLV_BYTES  = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  AXVALID,
  output logic                  AXREADY,
  input  logic [AXI_IW-1:0]     AXID,
  input  logic [AXI_AW-1:0]     AXADDR,
  input  logic [AXI_LW-1:0]     AXLEN,
  input  logic [AXI_SW-1:0]     AXSIZE,
  input  logic [AXI_BURSTW-1:0] AXBURST,
  output logic                  BEAT_VALID,
  input  logic                  BEAT_READY,
  output logic [AXI_AW-1:0]     BEAT_ADDR,
  output logic [AXI_IW-1:0]     BEAT_ID,
  output logic [AXI_LW-1:0]     BEAT_IDX,
  output logic                  BEAT_LAST,
  output logic                  BEAT_ERR,
  output logic                  BUSY
);

  localparam logic [AXI_SW-1:0]     SIZE_MAX = AXI_SW'($clog2(SLV_BYTES));
  localparam logic [AXI_BURSTW-1:0] B_FIXED  = AXI_BURSTW'(0);
  localparam logic [AXI_BURSTW-1:0] B_INCR   = AXI_BURSTW'(1);
  localparam logic [AXI_BURSTW-1:0] B_WRAP   = AXI_BURSTW'(2);
  localparam logic [AXI_BURSTW-1:0] B_RSVD   = AXI_BURSTW'(3);

  typedef enum logic {S_IDLE = 1'b0, S_BURST = 1'b1} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    r_valid;
  logic [AXI_AW-1:0]       r_addr;
  logic [AXI_IW-1:0]       r_id;
  logic [AXI_LW-1:0]       r_idx;
  logic [AXI_LW-1:0]       r_len;
  logic                    r_last;
  logic                    r_err;
  logic [AXI_SW-1:0]       r_size;   // clamped size used for arithmetic
  logic [AXI_BURSTW-1:0]   r_mode;   // burst type actually used for addresses
  logic [AXI_AW-1:0]       r_wmask;  // wrap window bytes minus one

  logic                    w_beat_hs;
  logic                    w_req_hs;
  logic                    w_axready;
  logic [AXI_SW-1:0]       w_size_eff;
  logic                    w_len_ok;
  logic [AXI_AW-1:0]       w_align_mask;
  logic [AXI_BURSTW-1:0]   w_mode;
  logic                    w_err;
  logic [AXI_AW-1:0]       w_wmask;
  logic [AXI_AW-1:0]       w_step;
  logic [AXI_AW-1:0]       w_incr;
  logic [AXI_AW-1:0]       w_next_addr;

  assign w_beat_hs = r_valid && BEAT_READY;
  // Ready while idle, or when the final beat leaves this cycle (zero-bubble chaining).
  assign w_axready = !ARESET && ((r_state == S_IDLE) || (w_beat_hs && r_last));
  assign w_req_hs  = AXVALID && w_axready;

  assign AXREADY    = w_axready;
  assign BEAT_VALID = r_valid;
  assign BEAT_ADDR  = r_addr;
  assign BEAT_ID    = r_id;
  assign BEAT_IDX   = r_idx;
  assign BEAT_LAST  = r_last;
  assign BEAT_ERR   = r_err;
  assign BUSY       = (r_state == S_BURST);

  // State register.
  always_ff @(posedge ACLK) begin
    if (ARESET) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state: a last-beat handshake ends the burst unless a new one is taken.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_req_hs) w_state_nxt = S_BURST;
      S_BURST: if (w_beat_hs && r_last && !w_req_hs) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Request decode: legality check, clamped size and address mode chosen at capture.
  always_comb begin
    w_size_eff   = (AXSIZE > SIZE_MAX) ? SIZE_MAX : AXSIZE;
    w_len_ok     = (AXLEN == AXI_LW'(1)) || (AXLEN == AXI_LW'(3)) ||
                   (AXLEN == AXI_LW'(7)) || (AXLEN == AXI_LW'(15));
    w_align_mask = (AXI_AW'(1) << w_size_eff) - AXI_AW'(1);
    w_wmask      = ((AXI_AW'(AXLEN) + AXI_AW'(1)) << w_size_eff) - AXI_AW'(1);
    w_mode       = AXBURST;
    if (AXBURST == B_RSVD)                 w_mode = B_FIXED;
    else if (AXBURST == B_WRAP && !w_len_ok) w_mode = B_INCR;
    w_err = (AXSIZE > SIZE_MAX) || (AXBURST == B_RSVD) ||
            ((AXBURST == B_WRAP) && !w_len_ok) ||
            ((AXBURST == B_WRAP) && ((AXADDR & w_align_mask) != '0));
  end

  // Next beat address from the current one; wrap keeps the window's upper bits.
  always_comb begin
    w_step      = AXI_AW'(1) << r_size;
    w_incr      = (r_addr & ~(w_step - AXI_AW'(1))) + w_step;
    w_next_addr = w_incr;
    case (r_mode)
      B_FIXED: w_next_addr = r_addr;
      B_WRAP:  w_next_addr = (r_addr & ~r_wmask) | (w_incr & r_wmask);
      default: w_next_addr = w_incr;
    endcase
  end

  // Beat descriptor registers: load on request, advance on non-last beat handshake.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_id    <= '0;
      r_idx   <= '0;
      r_len   <= '0;
      r_last  <= 1'b0;
      r_err   <= 1'b0;
      r_size  <= '0;
      r_mode  <= '0;
      r_wmask <= '0;
    end else if (w_req_hs) begin
      r_valid <= 1'b1;
      r_addr  <= AXADDR;
      r_id    <= AXID;
      r_idx   <= '0;
      r_len   <= AXLEN;
      r_last  <= (AXLEN == '0);
      r_err   <= w_err;
      r_size  <= w_size_eff;
      r_mode  <= w_mode;
      r_wmask <= w_wmask;
    end else if (w_beat_hs) begin
      if (r_last) begin
        r_valid <= 1'b0;
      end else begin
        r_addr <= w_next_addr;
        r_idx  <= r_idx + AXI_LW'(1);
        r_last <= ((r_idx + AXI_LW'(1)) == r_len);
      end
    end
  end

endmodule

// File: tb/tb_asi_beat_addr_gen.sv
// Directed bench for asi_beat_addr_gen: expected beats are pushed into a queue
// when each request is issued; a negedge monitor pops and compares every beat.
module tb_asi_beat_addr_gen;

  logic        clk;
  logic        ARESET;
  logic        AXVALID;
  logic        AXREADY;
  logic [7:0]  AXID;
  logic [39:0] AXADDR;
  logic [7:0]  AXLEN;
  logic [2:0]  AXSIZE;
  logic [1:0]  AXBURST;
  logic        BEAT_VALID;
  logic        BEAT_READY;
  logic [39:0] BEAT_ADDR;
  logic [7:0]  BEAT_ID;
  logic [7:0]  BEAT_IDX;
  logic        BEAT_LAST;
  logic        BEAT_ERR;
  logic        BUSY;

  // {addr, id, idx, last, err}
  logic [57:0] exp_q[$];
  int          n_checks;
  int          n_fail;
  int          waited;

  asi_beat_addr_gen dut (
    .ACLK       (clk),
    .ARESET     (ARESET),
    .AXVALID    (AXVALID),
    .AXREADY    (AXREADY),
    .AXID       (AXID),
    .AXADDR     (AXADDR),
    .AXLEN      (AXLEN),
    .AXSIZE     (AXSIZE),
    .AXBURST    (AXBURST),
    .BEAT_VALID (BEAT_VALID),
    .BEAT_READY (BEAT_READY),
    .BEAT_ADDR  (BEAT_ADDR),
    .BEAT_ID    (BEAT_ID),
    .BEAT_IDX   (BEAT_IDX),
    .BEAT_LAST  (BEAT_LAST),
    .BEAT_ERR   (BEAT_ERR),
    .BUSY       (BUSY)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [39:0] addr, input logic [7:0] id,
                          input logic [7:0] idx, input logic last, input logic err);
    exp_q.push_back({addr, id, idx, last, err});
  endtask

  // Drive one request and hold it until accepted; returns cycles spent waiting.
  task automatic send(input logic [7:0] id, input logic [39:0] addr, input logic [7:0] len,
                      input logic [2:0] size, input logic [1:0] burst, output int wcyc);
    bit accepted;
    accepted = 1'b0;
    wcyc     = 0;
    AXID = id; AXADDR = addr; AXLEN = len; AXSIZE = size; AXBURST = burst;
    AXVALID = 1'b1;
    while (!accepted && wcyc < 50) begin
      @(negedge clk);
      if (AXREADY) accepted = 1'b1;
      else         wcyc++;
      @(posedge clk); #1;
    end
    AXVALID = 1'b0;
    if (!accepted) check("accept_timeout", 64'd0, 64'd1);
  endtask

  // Wait (bounded) for all expected beats to be consumed.
  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  // Monitor: every beat handshake is compared against the head of the queue.
  always @(negedge clk) begin
    if (!ARESET && BEAT_VALID && BEAT_READY) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", {6'd0, BEAT_ADDR, BEAT_ID, BEAT_IDX, BEAT_LAST, BEAT_ERR}, 64'd0);
      end else begin
        check("beat", {6'd0, BEAT_ADDR, BEAT_ID, BEAT_IDX, BEAT_LAST, BEAT_ERR},
              {6'd0, exp_q.pop_front()});
      end
    end
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0; n_fail = 0;
    ARESET = 1'b1; AXVALID = 1'b0; AXID = '0; AXADDR = '0; AXLEN = '0;
    AXSIZE = '0; AXBURST = '0; BEAT_READY = 1'b1;

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 64'(BEAT_VALID), 64'd0);
    check("rst_addr",  64'(BEAT_ADDR),  64'd0);
    check("rst_id",    64'(BEAT_ID),    64'd0);
    check("rst_idx",   64'(BEAT_IDX),   64'd0);
    check("rst_last",  64'(BEAT_LAST),  64'd0);
    check("rst_err",   64'(BEAT_ERR),   64'd0);
    check("rst_busy",  64'(BUSY),       64'd0);
    check("rst_axready", 64'(AXREADY),  64'd0);
    @(posedge clk); #1;
    ARESET = 1'b0;
    #1;
    check("post_rst_axready", 64'(AXREADY), 64'd1);

    // INCR size 4 len 3 unaligned start.
    push_exp(40'h1008, 8'h01, 8'd0, 1'b0, 1'b0);
    push_exp(40'h1010, 8'h01, 8'd1, 1'b0, 1'b0);
    push_exp(40'h1020, 8'h01, 8'd2, 1'b0, 1'b0);
    push_exp(40'h1030, 8'h01, 8'd3, 1'b1, 1'b0);
    send(8'h01, 40'h1008, 8'd3, 3'd4, 2'd1, waited);
    check("incr_latency_valid", 64'(BEAT_VALID), 64'd1);
    check("incr_busy", 64'(BUSY), 64'd1);
    drain();
    check("idle_busy", 64'(BUSY), 64'd0);

    // WRAP size 4 len 3.
    push_exp(40'h1030, 8'h02, 8'd0, 1'b0, 1'b0);
    push_exp(40'h1000, 8'h02, 8'd1, 1'b0, 1'b0);
    push_exp(40'h1010, 8'h02, 8'd2, 1'b0, 1'b0);
    push_exp(40'h1020, 8'h02, 8'd3, 1'b1, 1'b0);
    send(8'h02, 40'h1030, 8'd3, 3'd4, 2'd2, waited);
    drain();

    // FIXED len 2.
    push_exp(40'h2004, 8'h03, 8'd0, 1'b0, 1'b0);
    push_exp(40'h2004, 8'h03, 8'd1, 1'b0, 1'b0);
    push_exp(40'h2004, 8'h03, 8'd2, 1'b1, 1'b0);
    send(8'h03, 40'h2004, 8'd2, 3'd2, 2'd0, waited);
    drain();

    // Back-to-back len-0 bursts with no bubble.
    push_exp(40'h4000, 8'h11, 8'd0, 1'b1, 1'b0);
    push_exp(40'h4100, 8'h22, 8'd0, 1'b1, 1'b0);
    send(8'h11, 40'h4000, 8'd0, 3'd4, 2'd1, waited);
    check("b2b_wait1", 64'(waited), 64'd0);
    check("b2b_valid1", 64'(BEAT_VALID), 64'd1);
    send(8'h22, 40'h4100, 8'd0, 3'd4, 2'd1, waited);
    check("b2b_wait2", 64'(waited), 64'd0);
    check("b2b_valid2", 64'(BEAT_VALID), 64'd1);
    check("b2b_id2", 64'(BEAT_ID), 64'h22);
    drain();

    // Address wrap at 2^40 with a 3-cycle stall on beat 0.
    BEAT_READY = 1'b0;
    push_exp(40'hFF_FFFF_FFF0, 8'h44, 8'd0, 1'b0, 1'b0);
    push_exp(40'h00_0000_0000, 8'h44, 8'd1, 1'b1, 1'b0);
    send(8'h44, 40'hFF_FFFF_FFF0, 8'd1, 3'd4, 2'd1, waited);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_valid", 64'(BEAT_VALID), 64'd1);
      check("stall_addr",  64'(BEAT_ADDR),  64'hFF_FFFF_FFF0);
      check("stall_idx",   64'(BEAT_IDX),   64'd0);
      check("stall_last",  64'(BEAT_LAST),  64'd0);
      check("stall_id",    64'(BEAT_ID),    64'h44);
      check("stall_axready", 64'(AXREADY),  64'd0);
      @(posedge clk); #1;
    end
    BEAT_READY = 1'b1;
    drain();

    // Illegal: reserved burst type, addresses as FIXED.
    push_exp(40'h500, 8'h51, 8'd0, 1'b0, 1'b1);
    push_exp(40'h500, 8'h51, 8'd1, 1'b1, 1'b1);
    send(8'h51, 40'h500, 8'd1, 3'd2, 2'd3, waited);
    drain();

    // Illegal: WRAP with len 2, addresses as INCR.
    push_exp(40'h100, 8'h52, 8'd0, 1'b0, 1'b1);
    push_exp(40'h110, 8'h52, 8'd1, 1'b0, 1'b1);
    push_exp(40'h120, 8'h52, 8'd2, 1'b1, 1'b1);
    send(8'h52, 40'h100, 8'd2, 3'd4, 2'd2, waited);
    drain();

    // Illegal: size 5, arithmetic uses 16-byte step.
    push_exp(40'h200, 8'h53, 8'd0, 1'b0, 1'b1);
    push_exp(40'h210, 8'h53, 8'd1, 1'b1, 1'b1);
    send(8'h53, 40'h200, 8'd1, 3'd5, 2'd1, waited);
    drain();

    // Illegal: unaligned WRAP, wraps from aligned lower bits.
    push_exp(40'h1038, 8'h54, 8'd0, 1'b0, 1'b1);
    push_exp(40'h1020, 8'h54, 8'd1, 1'b1, 1'b1);
    send(8'h54, 40'h1038, 8'd1, 3'd4, 2'd2, waited);
    drain();

    // Reset at beat 2 of a len-7 INCR burst.
    push_exp(40'h3000, 8'h33, 8'd0, 1'b0, 1'b0);
    push_exp(40'h3010, 8'h33, 8'd1, 1'b0, 1'b0);
    send(8'h33, 40'h3000, 8'd7, 3'd4, 2'd1, waited);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_idx", 64'(BEAT_IDX), 64'd2);
    ARESET = 1'b1;
    BEAT_READY = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_valid", 64'(BEAT_VALID), 64'd0);
    check("mid_rst_busy",  64'(BUSY),       64'd0);
    check("mid_rst_queue", 64'(exp_q.size()), 64'd0);
    ARESET = 1'b0;
    #1;
    check("after_rst_axready", 64'(AXREADY), 64'd1);
    BEAT_READY = 1'b1;
    push_exp(40'h6000, 8'h66, 8'd0, 1'b1, 1'b0);
    send(8'h66, 40'h6000, 8'd0, 3'd4, 2'd1, waited);
    drain();
    repeat (5) begin @(posedge clk); #1; end
    check("final_valid", 64'(BEAT_VALID), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
